// File: rtl/ptp_ts_pkg.sv
// Shared PTP timestamp definitions: default widths, field splits, queue entry.
// Used by ptp_ts_queue (optional tag feature: PTP_TS_QUEUE_TAG_EN).
package ptp_ts_pkg;

    localparam int TS_W_DEF  = 96;
    localparam int TAG_W_DEF = 16;

    // 96-bit: 48-bit seconds, 32-bit nanoseconds, 16-bit fractional ns
    localparam int TS96_SEC_W  = 48;
    localparam int TS96_NS_W   = 32;
    localparam int TS96_FNS_W  = 16;
    localparam int TS96_NS_LSB = TS96_FNS_W;
    localparam int TS96_SEC_LSB = TS96_FNS_W + TS96_NS_W;

    // 64-bit: 32-bit seconds, 32-bit nanoseconds
    localparam int TS64_SEC_W  = 32;
    localparam int TS64_NS_W   = 32;
    localparam int TS64_SEC_LSB = TS64_NS_W;

    typedef struct packed {
        logic [TAG_W_DEF-1:0] tag;
        logic [TS_W_DEF-1:0]  ts;
    } ts_entry_t;

endpackage

// File: rtl/ptp_ts_queue_ram.sv
// Simple dual-port storage: one synchronous write port, one async read port.
// Contents are intentionally not reset.
module ptp_ts_queue_ram #(
    parameter int WIDTH  = 96,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ptp_ts_queue.sv
// PTP timestamp FIFO with drop counting; optional sequence tag when
// PTP_TS_QUEUE_TAG_EN is defined.
import ptp_ts_pkg::*;

module ptp_ts_queue #(
    parameter int TS_WIDTH   = TS_W_DEF,
    parameter int DEPTH_LOG2 = 3,
    parameter int TAG_WIDTH  = TAG_W_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TS_WIDTH-1:0]   s_ts,
    input  logic                  s_ts_valid,
    output logic [TS_WIDTH-1:0]   m_axis_ts,
`ifdef PTP_TS_QUEUE_TAG_EN
    output logic [TAG_WIDTH-1:0]  m_axis_ts_tag,
`endif
    output logic                  m_axis_ts_valid,
    input  logic                  m_axis_ts_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  drop,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

`ifdef PTP_TS_QUEUE_TAG_EN
    localparam int EW = TAG_WIDTH + TS_WIDTH;
`else
    localparam int EW = TS_WIDTH + 0 * TAG_WIDTH;
`endif

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          rd_fire;
    logic          wr_en;
    logic          drop_d;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    assign level           = wr_ptr - rd_ptr;
    assign full            = (level == PW'(DEPTH));
    assign m_axis_ts_valid = (level != '0);
    assign rd_fire         = m_axis_ts_valid && m_axis_ts_ready;
    // A full queue still accepts when the head leaves in the same cycle
    assign wr_en           = s_ts_valid && (!full || rd_fire);
    assign drop_d          = s_ts_valid && full && !rd_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop       <= 1'b0;
            drop_count <= '0;
        end else begin
            drop <= drop_d;
            if (drop_d && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

`ifdef PTP_TS_QUEUE_TAG_EN
    logic [TAG_WIDTH-1:0] tag_cnt;

    // Tag advances on every pulse so a dropped frame leaves a visible gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt <= '0;
        end else if (s_ts_valid) begin
            tag_cnt <= tag_cnt + 1'b1;
        end
    end

    assign wdata         = {tag_cnt, s_ts};
    assign m_axis_ts     = rdata[TS_WIDTH-1:0];
    assign m_axis_ts_tag = rdata[EW-1:TS_WIDTH];
`else
    assign wdata     = s_ts;
    assign m_axis_ts = rdata;
`endif

    ptp_ts_queue_ram #(
        .WIDTH  (EW),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (rdata)
    );

endmodule
